// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: state encoding, entry struct, default widths.
// No logic; imported by wb_arb_fifo and wb_port_arbiter.
// The optional forwarding lookup is enabled by defining WB_ARB_FWD_EN.
package wb_arb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_REG_AW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [DEF_REG_AW-1:0] waddr;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_arb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small synchronous FIFO holding multi-cycle results waiting for a free write-port cycle.
// Latency: a pushed entry is visible at head on the cycle after the push (no bypass).
// Backpressure: full is registered, so a pop only frees a push slot from the next cycle (WB_ARB_FWD_EN exposes storage).
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter type T          = wb_arb_entry_t,
    parameter int  DEPTH      = 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
`ifdef WB_ARB_FWD_EN
    ,
    output T [DEPTH-1:0]  entries,
    output logic [AW-1:0] rd_ptr
`endif
);

    T [DEPTH-1:0]  mem;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr_q;

    // Pointer and occupancy update; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr   <= wr_ptr + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage needs no reset; occupancy decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef WB_ARB_FWD_EN
    assign entries = mem;
    assign rd_ptr  = rd_ptr_q;
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between WB-stage writes and buffered multi-cycle results.
// Latency: pipe writes pass through combinationally; mc results reach the port no earlier than the next cycle.
// Backpressure: mc_ready = !full; pipe_stall rises only when a starved FIFO head forces a drain (WB_ARB_FWD_EN adds lookup).
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  REG_AW     = DEF_REG_AW,
    parameter int  FIFO_DEPTH = 2,
    parameter int  STARVE_MAX = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int SW         = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [REG_AW-1:0] pipe_reg,
    input  logic [DATA_W-1:0] pipe_data,
    output logic              pipe_stall,
    input  logic              mc_valid,
    input  logic [REG_AW-1:0] mc_reg,
    input  logic [DATA_W-1:0] mc_data,
    output logic              mc_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  fifo_count
`ifdef WB_ARB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_raddr0,
    input  logic [REG_AW-1:0] fwd_raddr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data0,
    output logic [DATA_W-1:0] fwd_data1
`endif
);

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    entry_t        mc_entry;
    entry_t        head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    assign mc_entry = '{waddr: mc_reg, wdata: mc_data};
    assign mc_ready = !fifo_full;
    assign push     = mc_valid && !fifo_full;

`ifdef WB_ARB_FWD_EN
    entry_t [FIFO_DEPTH-1:0] fifo_entries;
    logic [AW-1:0]           fifo_rd_ptr;
`endif

    wb_arb_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mc_entry),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
`ifdef WB_ARB_FWD_EN
        ,
        .entries   (fifo_entries),
        .rd_ptr    (fifo_rd_ptr)
`endif
    );

    // Write-port grant: pipe by default, FIFO head on idle pipe cycles or when starvation forces it.
    always_comb begin
        pop        = 1'b0;
        pipe_stall = 1'b0;
        rf_we      = pipe_valid;
        rf_waddr   = pipe_reg;
        rf_wdata   = pipe_data;
        case (state)
            PEND:    pop = !pipe_valid && !fifo_empty;
            FORCE: begin
                pop        = !fifo_empty;
                pipe_stall = pipe_valid;
            end
            default: pop = 1'b0;
        endcase
        if (pop) begin
            rf_we    = 1'b1;
            rf_waddr = head.waddr;
            rf_wdata = head.wdata;
        end
    end

    // Arbitration FSM with the starvation counter; every dequeue restarts the wait for the next head.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= PEND;
                end
                PEND: begin
                    if (pipe_valid) begin
                        starve_cnt <= starve_cnt + SW'(1);
                        if (starve_cnt == SW'(STARVE_MAX - 1)) state <= FORCE;
                    end else begin
                        starve_cnt <= '0;
                        if (fifo_count == CNT_W'(1) && !push) state <= IDLE;
                    end
                end
                FORCE: begin
                    starve_cnt <= '0;
                    state      <= (fifo_count == CNT_W'(1) && !push) ? IDLE : PEND;
                end
                default: begin
                    state      <= IDLE;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_FWD_EN
    // Forwarding lookup: scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [AW-1:0] idx;
        idx       = '0;
        fwd_hit0  = 1'b0;
        fwd_hit1  = 1'b0;
        fwd_data0 = '0;
        fwd_data1 = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = fifo_rd_ptr + AW'(i);
            if (CNT_W'(i) < fifo_count) begin
                if (fifo_entries[idx].waddr == fwd_raddr0) begin
                    fwd_hit0  = 1'b1;
                    fwd_data0 = fifo_entries[idx].wdata;
                end
                if (fifo_entries[idx].waddr == fwd_raddr1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = fifo_entries[idx].wdata;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed steps then random traffic, checked against a queue-based model.
// Inputs change after the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
// Build with WB_ARB_FWD_EN defined to also exercise the forwarding lookup.
module tb_wb_port_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct packed {
        logic [2:0]  r;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [2:0]  pipe_reg;
    logic [15:0] pipe_data;
    logic        pipe_stall;
    logic        mc_valid;
    logic [2:0]  mc_reg;
    logic [15:0] mc_data;
    logic        mc_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [1:0]  fifo_count;
`ifdef WB_ARB_FWD_EN
    logic [2:0]  fwd_raddr0 = 3'd0;
    logic [2:0]  fwd_raddr1 = 3'd0;
    logic        fwd_hit0, fwd_hit1;
    logic [15:0] fwd_data0, fwd_data1;
    logic        obs_hit0, obs_hit1;
    logic [15:0] obs_data0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: pending results in arrival order, cycles the current head has waited.
    ent_t q[$];
    int   wait_cnt = 0;

    // Observations from the most recent step.
    logic        obs_we, obs_stall, obs_ready;
    logic [2:0]  obs_addr;
    logic [15:0] obs_data;
    logic [1:0]  obs_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W     (16),
        .REG_AW     (3),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_reg   (pipe_reg),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mc_valid   (mc_valid),
        .mc_reg     (mc_reg),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .fifo_count (fifo_count)
`ifdef WB_ARB_FWD_EN
        ,
        .fwd_raddr0 (fwd_raddr0),
        .fwd_raddr1 (fwd_raddr1),
        .fwd_hit0   (fwd_hit0),
        .fwd_hit1   (fwd_hit1),
        .fwd_data0  (fwd_data0),
        .fwd_data1  (fwd_data1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic pv, input logic [2:0] pr, input logic [15:0] pd,
                        input logic mv, input logic [2:0] mr, input logic [15:0] md);
        logic        e_we, e_stall, e_ready, e_deq;
        logic [2:0]  e_addr;
        logic [15:0] e_data;
        @(negedge clk);
        rst        = r;
        pipe_valid = pv;
        pipe_reg   = pr;
        pipe_data  = pd;
        mc_valid   = mv;
        mc_reg     = mr;
        mc_data    = md;
        #1;
        obs_we    = rf_we;
        obs_stall = pipe_stall;
        obs_ready = mc_ready;
        obs_addr  = rf_waddr;
        obs_data  = rf_wdata;
        obs_count = fifo_count;
`ifdef WB_ARB_FWD_EN
        obs_hit0  = fwd_hit0;
        obs_hit1  = fwd_hit1;
        obs_data0 = fwd_data0;
`endif
        // Grant rules: empty -> pipe; starved head -> head and stall pipe; else pipe first, head when pipe idle.
        e_ready = (q.size() < DEPTH);
        e_deq   = 1'b0;
        e_stall = 1'b0;
        e_we    = pv;
        e_addr  = pr;
        e_data  = pd;
        if (q.size() > 0) begin
            if (wait_cnt >= STARVE) begin
                e_deq   = 1'b1;
                e_stall = pv;
            end else if (!pv) begin
                e_deq = 1'b1;
            end
        end
        if (e_deq) begin
            e_we   = 1'b1;
            e_addr = q[0].r;
            e_data = q[0].d;
        end
        if (!r) begin
            chk("fifo_count", 32'(obs_count), 32'(q.size()));
            chk("mc_ready", 32'(obs_ready), 32'(e_ready));
            chk("pipe_stall", 32'(obs_stall), 32'(e_stall));
            chk("rf_we", 32'(obs_we), 32'(e_we));
            if (e_we) begin
                chk("rf_waddr", 32'(obs_addr), 32'(e_addr));
                chk("rf_wdata", 32'(obs_data), 32'(e_data));
            end
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            wait_cnt = 0;
        end else begin
            if (e_deq) begin
                void'(q.pop_front());
                wait_cnt = 0;
            end else if (q.size() > 0 && pv) begin
                wait_cnt++;
            end
            if (mv && e_ready) q.push_back(ent_t'{r: mr, d: md});
        end
    endtask

    initial begin
        int lowcnt;
        logic        pv, mv;
        logic [2:0]  pr, mr;
        logic [15:0] pd, md;

        rst = 1'b1; pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_count", 32'(obs_count), 32'd0);
        chk("reset_ready", 32'(obs_ready), 32'd1);
        chk("reset_stall", 32'(obs_stall), 32'd0);
        chk("reset_we", 32'(obs_we), 32'd0);

        // Pipe write passes straight through.
        step(0, 1, 3'd3, 16'h1234, 0, 0, 0);
        chk("pipe_we", 32'(obs_we), 32'd1);
        chk("pipe_addr", 32'(obs_addr), 32'd3);
        chk("pipe_data", 32'(obs_data), 32'h1234);

        // Single mc result drains on the next idle cycle, then back to idle.
        step(0, 0, 0, 0, 1, 3'd5, 16'hBEEF);
        chk("mc_nopass_we", 32'(obs_we), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mc_count1", 32'(obs_count), 32'd1);
        chk("mc_drain_addr", 32'(obs_addr), 32'd5);
        chk("mc_drain_data", 32'(obs_data), 32'hBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("mc_idle_count", 32'(obs_count), 32'd0);
        chk("mc_idle_we", 32'(obs_we), 32'd0);

        // Starvation: pipe wins four times, the fifth cycle stalls the pipe and drains the head.
        step(0, 1, 3'd1, 16'h0001, 1, 3'd7, 16'h0A0A);
        for (int k = 0; k < STARVE; k++) begin
            step(0, 1, 3'd1, 16'h0001, 0, 0, 0);
            chk("starve_pipe_stall", 32'(obs_stall), 32'd0);
            chk("starve_pipe_addr", 32'(obs_addr), 32'd1);
        end
        step(0, 1, 3'd1, 16'h0001, 0, 0, 0);
        chk("force_stall", 32'(obs_stall), 32'd1);
        chk("force_addr", 32'(obs_addr), 32'd7);
        chk("force_data", 32'(obs_data), 32'h0A0A);
        step(0, 1, 3'd1, 16'h0001, 0, 0, 0);
        chk("after_force_stall", 32'(obs_stall), 32'd0);
        chk("after_force_count", 32'(obs_count), 32'd0);

        // Fill the FIFO with the pipe busy; a third result waits until the forced drain plus one cycle.
`ifdef WB_ARB_FWD_EN
        fwd_raddr0 = 3'd2;
        fwd_raddr1 = 3'd4;
`endif
        step(0, 1, 3'd1, 16'h0011, 1, 3'd2, 16'h0001);
        step(0, 1, 3'd1, 16'h0011, 1, 3'd2, 16'h0002);
        lowcnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 3'd1, 16'h0011, 1, 3'd4, 16'h0003);
            if (k == 0) begin
                chk("full_count", 32'(obs_count), 32'd2);
`ifdef WB_ARB_FWD_EN
                chk("fwd_hit0", 32'(obs_hit0), 32'd1);
                chk("fwd_data0", 32'(obs_data0), 32'h0002);
                chk("fwd_hit1", 32'(obs_hit1), 32'd0);
`endif
            end
            if (obs_ready) break;
            lowcnt++;
        end
        chk("held_cycles", 32'(lowcnt), 32'd4);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0);
        chk("full_drained", 32'(obs_count), 32'd0);

        // Same-cycle enqueue and dequeue across pointer wrap.
        step(0, 0, 0, 0, 1, 3'd6, 16'h1111);
        step(0, 0, 0, 0, 1, 3'd6, 16'h2222);
        chk("wrap_count_a", 32'(obs_count), 32'd1);
        chk("wrap_data_a", 32'(obs_data), 32'h1111);
        step(0, 0, 0, 0, 1, 3'd6, 16'h3333);
        chk("wrap_count_b", 32'(obs_count), 32'd1);
        chk("wrap_data_b", 32'(obs_data), 32'h2222);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_data_c", 32'(obs_data), 32'h3333);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset with two entries pending discards them.
        step(0, 1, 3'd2, 16'h00AA, 1, 3'd3, 16'h5555);
        step(0, 1, 3'd2, 16'h00AA, 1, 3'd4, 16'h6666);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_count", 32'(obs_count), 32'd0);
        chk("rst_flush_we", 32'(obs_we), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_we2", 32'(obs_we), 32'd0);

        // Random traffic: stalled pipe writes and refused mc results are held, as real sources would.
        pv = 0; pr = 0; pd = 0; mv = 0; mr = 0; md = 0;
        for (int n = 0; n < 400; n++) begin
            logic r;
            if (!(pv && obs_stall)) begin
                pv = ($urandom_range(0, 99) < 65);
                pr = 3'($urandom);
                pd = 16'($urandom);
            end
            if (!(mv && !obs_ready)) begin
                mv = ($urandom_range(0, 99) < 35);
                mr = 3'($urandom);
                md = 16'($urandom);
            end
            r = ($urandom_range(0, 99) < 2);
            step(r, pv, pr, pd, mv, mr, md);
            if (r) begin
                pv = 0;
                mv = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
